// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the round sequencer slice.
//   - rs_state_e : state codes of round_sequencer (IDLE=0 .. OVER=4)
//   - *_W        : widths of the lives, scrolls and time counters, plus the
//                  frame and banner counters
package game_pkg;

  localparam int LIVES_W  = 3;
  localparam int SCROLL_W = 4;
  localparam int TIME_W   = 7;
  localparam int FRAME_W  = 8;
  localparam int BANNER_W = 8;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_PLAY  = 3'd1,
    RS_HIT   = 3'd2,
    RS_CLEAR = 3'd3,
    RS_OVER  = 3'd4
  } rs_state_e;

endpackage

// File: rtl/frame_sec_timer.sv
// frame_sec_timer: per-life countdown in whole seconds, advanced only by
// frame ticks.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   load           : reload time_left with TIME_LIMIT_S and clear the frame count
//   run            : allow frame_tick to advance the count this cycle
//   time_left      : registered seconds remaining
//   expire         : combinational, high in the cycle whose clock edge moves
//                    time_left from 1 to 0 (one cycle wide)
module frame_sec_timer
  import game_pkg::*;
#(
  parameter int TIME_LIMIT_S   = 60,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              load,
  input  logic              run,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(TIME_LIMIT_S);

  logic [FRAME_W-1:0] frameCnt;
  logic               secondDone;

  assign secondDone = run && frame_tick && (frameCnt == LAST_FRAME);
  // load and run are never both asserted by the sequencer, so expire does
  // not look at load; that keeps it free of a path back into the FSM logic.
  assign expire     = secondDone && (time_left == TIME_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frameCnt  <= '0;
      time_left <= '0;
    end else if (load) begin
      frameCnt  <= '0;
      time_left <= TIME_LOAD;
    end else if (run && frame_tick) begin
      if (frameCnt == LAST_FRAME) begin
        frameCnt <= '0;
        if (time_left != '0) begin
          time_left <= time_left - TIME_W'(1);
        end
      end else begin
        frameCnt <= frameCnt + FRAME_W'(1);
      end
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: sequences one round of play (arm/freeze motion, scroll
// count, per-life time limit, lives, level_passed / lose pulses).
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   frame_tick    : one-cycle pulse per video frame
//   start_btn     : level, rising edge starts a game / leaves OVER
//   scroll_hit    : one-cycle pulse per scroll collected
//   wall_hit      : level while overlapping a wall, rising edge is a fault
//   game_done     : sampled only when the CLEAR banner expires
//   move_en       : player motion allowed (registered)
//   level_passed  : one-cycle pulse on level completion
//   lose          : one-cycle pulse on losing the last life
//   lives         : lives remaining
//   scrolls_left  : scrolls still needed this level
//   time_left     : seconds remaining for the current life
//   banner_on     : high in HIT and CLEAR
//   state         : current state code (rs_state_e)
// level_passed and lose are fire-and-forget pulses: no handshake, the
// consumer must sample them on the cycle they are high.
module round_sequencer
  import game_pkg::*;
#(
  parameter int SCROLLS_PER_LEVEL = 4,
  parameter int LIVES             = 3,
  parameter int TIME_LIMIT_S      = 60,
  parameter int FRAMES_PER_SEC    = 60,
  parameter int BANNER_FRAMES     = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start_btn,
  input  logic                scroll_hit,
  input  logic                wall_hit,
  input  logic                game_done,
  output logic                move_en,
  output logic                level_passed,
  output logic                lose,
  output logic [LIVES_W-1:0]  lives,
  output logic [SCROLL_W-1:0] scrolls_left,
  output logic [TIME_W-1:0]   time_left,
  output logic                banner_on,
  output logic [2:0]          state
);

  localparam logic [BANNER_W-1:0] LAST_BANNER  = BANNER_W'(BANNER_FRAMES - 1);
  localparam logic [LIVES_W-1:0]  LIVES_LOAD   = LIVES_W'(LIVES);
  localparam logic [SCROLL_W-1:0] SCROLLS_LOAD = SCROLL_W'(SCROLLS_PER_LEVEL);

  rs_state_e           curState, nextState;
  logic [BANNER_W-1:0] bannerCnt, nextBanner;
  logic [LIVES_W-1:0]  nextLives;
  logic [SCROLL_W-1:0] nextScrolls;
  logic                nextLevelPassed, nextLose;
  logic                startPrev, wallPrev;
  logic                startRise, wallRise;
  logic                levelDone;
  logic                timerLoad, timerRun, timerExpire;

  assign state     = curState;
  assign startRise = start_btn && !startPrev;
  assign wallRise  = wall_hit && !wallPrev;
  assign levelDone = (curState == RS_PLAY) && scroll_hit &&
                     (scrolls_left == SCROLL_W'(1));

  // The clock stops for a completed level and for a wall fault in the same
  // cycle, so a simultaneous second boundary neither decrements time_left
  // nor registers a second fault.
  assign timerRun = (curState == RS_PLAY) && !levelDone && !wallRise;

  frame_sec_timer #(
    .TIME_LIMIT_S   (TIME_LIMIT_S),
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .load       (timerLoad),
    .run        (timerRun),
    .time_left  (time_left),
    .expire     (timerExpire)
  );

  always_comb begin
    nextState       = curState;
    nextLives       = lives;
    nextScrolls     = scrolls_left;
    nextBanner      = bannerCnt;
    nextLevelPassed = 1'b0;
    nextLose        = 1'b0;
    timerLoad       = 1'b0;

    case (curState)
      RS_IDLE: begin
        if (startRise) begin
          nextLives   = LIVES_LOAD;
          nextScrolls = SCROLLS_LOAD;
          timerLoad   = 1'b1;
          nextState   = RS_PLAY;
        end
      end

      RS_PLAY: begin
        if (levelDone) begin
          // Completion outranks any fault arriving in the same cycle.
          nextScrolls     = '0;
          nextLevelPassed = 1'b1;
          nextBanner      = '0;
          nextState       = RS_CLEAR;
        end else begin
          if (scroll_hit && (scrolls_left != '0)) begin
            nextScrolls = scrolls_left - SCROLL_W'(1);
          end
          if (wallRise || timerExpire) begin
            if (lives > LIVES_W'(1)) begin
              nextLives  = lives - LIVES_W'(1);
              nextBanner = '0;
              nextState  = RS_HIT;
            end else begin
              nextLives = '0;
              nextLose  = 1'b1;
              nextState = RS_OVER;
            end
          end
        end
      end

      RS_HIT, RS_CLEAR: begin
        if (frame_tick) begin
          if (bannerCnt == LAST_BANNER) begin
            nextBanner = '0;
            if ((curState == RS_CLEAR) && game_done) begin
              nextState = RS_OVER;
            end else begin
              timerLoad = 1'b1;
              nextState = RS_PLAY;
              if (curState == RS_CLEAR) begin
                nextScrolls = SCROLLS_LOAD;
              end
            end
          end else begin
            nextBanner = bannerCnt + BANNER_W'(1);
          end
        end
      end

      RS_OVER: begin
        if (startRise) begin
          nextState = RS_IDLE;
        end
      end

      default: begin
        nextState = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState     <= RS_IDLE;
      bannerCnt    <= '0;
      lives        <= '0;
      scrolls_left <= '0;
      level_passed <= 1'b0;
      lose         <= 1'b0;
      move_en      <= 1'b0;
      banner_on    <= 1'b0;
      startPrev    <= 1'b0;
      wallPrev     <= 1'b0;
    end else begin
      curState     <= nextState;
      bannerCnt    <= nextBanner;
      lives        <= nextLives;
      scrolls_left <= nextScrolls;
      level_passed <= nextLevelPassed;
      lose         <= nextLose;
      move_en      <= (nextState == RS_PLAY);
      banner_on    <= (nextState == RS_HIT) || (nextState == RS_CLEAR);
      startPrev    <= start_btn;
      wallPrev     <= wall_hit;
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int SPL = 4;
  localparam int NL  = 3;
  localparam int TL  = 60;
  localparam int FPS = 60;
  localparam int BF  = 120;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start_btn = 1'b0, scroll_hit = 1'b0;
  logic       wall_hit = 1'b0, game_done = 1'b0;
  logic       move_en, level_passed, lose, banner_on;
  logic [2:0] lives;
  logic [3:0] scrolls_left;
  logic [6:0] time_left;
  logic [2:0] state;

  always #5 clk = ~clk;

  round_sequencer #(
    .SCROLLS_PER_LEVEL (SPL),
    .LIVES             (NL),
    .TIME_LIMIT_S      (TL),
    .FRAMES_PER_SEC    (FPS),
    .BANNER_FRAMES     (BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .scroll_hit   (scroll_hit),
    .wall_hit     (wall_hit),
    .game_done    (game_done),
    .move_en      (move_en),
    .level_passed (level_passed),
    .lose         (lose),
    .lives        (lives),
    .scrolls_left (scrolls_left),
    .time_left    (time_left),
    .banner_on    (banner_on),
    .state        (state)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;
  logic [1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  // States as plain ints: 0 idle, 1 play, 2 hit, 3 clear, 4 over.
  int m_state = 0, m_lives = 0, m_scrolls = 0, m_time = 0;
  int m_frames = 0, m_banner = 0;
  bit m_prev_start = 0, m_prev_wall = 0, m_lp = 0, m_lose = 0;

  always @(posedge clk or negedge rst) begin : model_blk
    bit s_rise, w_rise, done_lvl, t_fault;
    if (!rst) begin
      m_state = 0; m_lives = 0; m_scrolls = 0; m_time = 0;
      m_frames = 0; m_banner = 0; m_prev_start = 0; m_prev_wall = 0;
      m_lp = 0; m_lose = 0;
      exp_q.delete();
    end else begin
      s_rise = start_btn && !m_prev_start;
      w_rise = wall_hit && !m_prev_wall;
      m_lp = 0;
      m_lose = 0;
      if (m_state == 0) begin
        if (s_rise) begin
          m_lives = NL; m_scrolls = SPL; m_time = TL; m_frames = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        done_lvl = scroll_hit && (m_scrolls == 1);
        t_fault  = frame_tick && (m_frames == FPS - 1) && (m_time == 1) && !w_rise;
        if (done_lvl) begin
          m_scrolls = 0; m_lp = 1; m_banner = 0; m_state = 3;
        end else begin
          if (scroll_hit && m_scrolls > 0) m_scrolls--;
          if (w_rise || t_fault) begin
            if (t_fault) begin
              m_time = 0; m_frames = 0;
            end
            if (m_lives > 1) begin
              m_lives--; m_banner = 0; m_state = 2;
            end else begin
              m_lives = 0; m_lose = 1; m_state = 4;
            end
          end else if (frame_tick) begin
            if (m_frames == FPS - 1) begin
              m_frames = 0;
              if (m_time > 0) m_time--;
            end else begin
              m_frames++;
            end
          end
        end
      end else if (m_state == 2 || m_state == 3) begin
        if (frame_tick) begin
          if (m_banner == BF - 1) begin
            m_banner = 0;
            if (m_state == 3 && game_done) begin
              m_state = 4;
            end else begin
              if (m_state == 3) m_scrolls = SPL;
              m_time = TL; m_frames = 0; m_state = 1;
            end
          end else begin
            m_banner++;
          end
        end
      end else begin
        if (s_rise) m_state = 0;
      end
      m_prev_start = start_btn;
      m_prev_wall  = wall_hit;
      if (m_lp)   exp_q.push_back(2'b01);
      if (m_lose) exp_q.push_back(2'b10);
    end
  end

  // ---------------- per-cycle compare + pulse scoreboard ----------------
  always @(negedge clk) begin : cmp_blk
    logic [20:0] got, want;
    logic [1:0]  e;
    if (cmp_en) begin
      got  = {state, move_en, level_passed, lose, lives, scrolls_left, time_left, banner_on};
      want = {3'(m_state), (m_state == 1), m_lp, m_lose, 3'(m_lives), 4'(m_scrolls),
              7'(m_time), (m_state == 2 || m_state == 3)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got st=%0d mv=%0b lp=%0b lo=%0b li=%0d sc=%0d tm=%0d bn=%0b want st=%0d mv=%0b lp=%0b lo=%0b li=%0d sc=%0d tm=%0d bn=%0b",
                 $time, got[20:18], got[17], got[16], got[15], got[14:12], got[11:8], got[7:1], got[0],
                 want[20:18], want[17], want[16], want[15], want[14:12], want[11:8], want[7:1], want[0]);
      end
      if (level_passed || lose) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected t=%0t got lose/lp=%b want none", $time, {lose, level_passed});
        end else begin
          e = exp_q.pop_front();
          if (e !== {lose, level_passed}) begin
            errors++;
            $display("FAIL pulse_kind t=%0t got lose/lp=%b want %b", $time, {lose, level_passed}, e);
          end
        end
      end
      if (errors >= 40) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ft, input logic sb, input logic sh, input logic wh);
    @(negedge clk);
    #1;
    frame_tick = ft; start_btn = sb; scroll_hit = sh; wall_hit = wh;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic wh);
    repeat (n) drive(1'b1, 1'b0, 1'b0, wh);
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    bit seen;
    logic wh_r;

    #1 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_lit("reset_state", state, 0);
    check_lit("reset_move", move_en, 0);
    check_lit("reset_lives", lives, 0);
    check_lit("reset_time", time_left, 0);
    @(negedge clk);
    #1 rst = 1'b1;

    // start a game
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    settle();
    check_lit("start_state", state, 1);
    check_lit("start_move", move_en, 1);
    check_lit("start_lives", lives, 3);
    check_lit("start_scrolls", scrolls_left, 4);
    check_lit("start_time", time_left, 60);
    drive(0, 0, 0, 0);

    // collect a level
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
    end
    settle();
    check_lit("scrolls_one_left", scrolls_left, 1);
    drive(0, 0, 1, 0);
    settle();
    check_lit("level_pulse", level_passed, 1);
    check_lit("clear_state", state, 3);
    check_lit("clear_banner", banner_on, 1);
    drive(0, 0, 0, 0);
    settle();
    check_lit("level_pulse_width", level_passed, 0);
    ticks(BF - 1, 0);
    settle();
    check_lit("clear_hold", state, 3);
    drive(1, 0, 0, 0);
    settle();
    check_lit("clear_exit_state", state, 1);
    check_lit("clear_exit_scrolls", scrolls_left, 4);

    // wall fault, held wall does not refault
    drive(0, 0, 0, 1);
    settle();
    check_lit("hit_lives", lives, 2);
    check_lit("hit_state", state, 2);
    check_lit("hit_move", move_en, 0);
    ticks(BF, 1);
    settle();
    check_lit("hit_exit_state", state, 1);
    check_lit("hit_exit_time", time_left, 60);
    repeat (10) drive(0, 0, 0, 1);
    settle();
    check_lit("held_wall_lives", lives, 2);
    check_lit("held_wall_state", state, 1);
    drive(0, 0, 0, 0);
    ticks(FPS, 0);
    settle();
    check_lit("one_second", time_left, 59);

    // last scroll and wall rise together
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    settle();
    check_lit("tie_level_pulse", level_passed, 1);
    check_lit("tie_lives", lives, 2);
    check_lit("tie_state", state, 3);
    drive(0, 0, 0, 0);
    game_done = 1'b0;
    ticks(BF, 0);
    settle();
    check_lit("tie_exit_state", state, 1);
    check_lit("tie_exit_scrolls", scrolls_left, 4);

    // asynchronous reset in HIT
    drive(0, 0, 0, 1);
    ticks(10, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_lit("async_state", state, 0);
    check_lit("async_lives", lives, 0);
    check_lit("async_banner", banner_on, 0);
    check_lit("async_scrolls", scrolls_left, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 0, 1, logic'(i % 2));
    settle();
    check_lit("post_reset_idle", state, 0);
    check_lit("post_reset_time", time_left, 0);

    // new game, lose two lives by walls, then time out the last one
    drive(0, 1, 0, 0);
    settle();
    check_lit("restart_lives", lives, 3);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      ticks(BF, 0);
    end
    settle();
    check_lit("last_life", lives, 1);
    check_lit("last_life_time", time_left, 60);
    n = 0;
    seen = 0;
    while (n < 4000 && !seen) begin
      drive(1, 0, 0, 0);
      n++;
      settle();
      if (lose === 1'b1) seen = 1;
    end
    check_lit("lose_seen", seen, 1);
    check_lit("lose_tick_count", n, TL * FPS);
    check_lit("over_state", state, 4);
    check_lit("over_time", time_left, 0);
    check_lit("over_lives", lives, 0);
    drive(0, 0, 0, 0);
    settle();
    check_lit("lose_width", lose, 0);

    // OVER -> IDLE -> PLAY needs two rises
    drive(0, 1, 0, 0);
    settle();
    check_lit("over_to_idle", state, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    settle();
    check_lit("idle_to_play", state, 1);

    // CLEAR with game_done goes to OVER without lose
    repeat (4) drive(0, 0, 1, 0);
    game_done = 1'b1;
    ticks(BF, 0);
    settle();
    check_lit("done_over_state", state, 4);
    check_lit("done_over_lives", lives, 3);
    game_done = 1'b0;

    // randomized phase
    wh_r = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 14) == 0) wh_r = ~wh_r;
      game_done = logic'($urandom_range(0, 1));
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 39) == 0),
            logic'($urandom_range(0, 9) == 0), wh_r);
      if ($urandom_range(0, 4999) == 0) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    drive(0, 0, 0, 0);
    settle();
    settle();
    check_lit("pulse_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequences one round of play: it arms and freezes player motion, counts collected scrolls, enforces a per-life time limit, tracks lives, and generates the `levelPassed` / `lose` pulses consumed by `GameFSM`. It sits in `Game` between the collision outputs of `Scrolls` / `Obstacles` and `GameFSM`. Its `move_en` output gates `PlayerObject` motion.

## Interface
Parameters:
- `SCROLLS_PER_LEVEL`, default 4: scrolls to collect per level; range 1..15.
- `LIVES`, default 3: lives per game; range 1..7.
- `TIME_LIMIT_S`, default 60: seconds allowed per life; range 1..127.
- `FRAMES_PER_SEC`, default 60: frame ticks per second; range 1..255.
- `BANNER_FRAMES`, default 120: freeze length after a hit or a level clear; range 1..255.

Ports:
- `clk`, in, 1: system clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous reset, active-low. Asserted (0) forces the reset values immediately.
- `frame_tick`, in, 1: one-cycle pulse per video frame (start of VS).
- `start_btn`, in, 1: synchronous level. Rising edge detected internally.
- `scroll_hit`, in, 1: one-cycle pulse per scroll collected.
- `wall_hit`, in, 1: level, high while the player overlaps a wall. Rising edge detected internally.
- `game_done`, in, 1: high when `GameFSM` reports game won or game over.
- `move_en`, out, 1: player motion allowed.
- `level_passed`, out, 1: one-cycle pulse to `GameFSM.levelPassed`.
- `lose`, out, 1: one-cycle pulse to `GameFSM.lose`.
- `lives`, out, 3: lives remaining.
- `scrolls_left`, out, 4: scrolls still needed this level.
- `time_left`, out, 7: seconds remaining for the current life.
- `banner_on`, out, 1: high in HIT and CLEAR.
- `state`, out, 3: current state code.

## Operation
- States and codes: IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4. Codes 5..7 are unreachable and recover to IDLE.
- Reset values: state IDLE; all outputs 0; frame and banner counters 0; edge-detect registers 0.
- IDLE:
  - `move_en`=0.
  - On `start_btn` rise: lives←LIVES, scrolls_left←SCROLLS_PER_LEVEL, time_left←TIME_LIMIT_S, frame_cnt←0, then go to PLAY.
- PLAY, `move_en`=1:
  - `scroll_hit` decrements `scrolls_left`, saturating at 0.
  - Decrement from 1 to 0: pulse `level_passed`, banner_cnt←0, go to CLEAR.
  - `frame_tick` increments frame_cnt. At FRAMES_PER_SEC−1, frame_cnt←0 and time_left decrements, saturating at 0.
  - A fault is a `wall_hit` rise, or time_left going from 1 to 0.
  - Fault with lives>1: lives−1, banner_cnt←0, go to HIT.
  - Fault with lives==1: lives←0, pulse `lose`, go to OVER.
- Priority within one cycle: level completion beats a fault. A fault beats the timer decrement.
- HIT:
  - `move_en`=0. Each `frame_tick` increments banner_cnt.
  - At BANNER_FRAMES−1: time_left←TIME_LIMIT_S, frame_cnt←0, go to PLAY.
  - `scrolls_left` is retained.
  - `scroll_hit` and `wall_hit` are ignored in this state.
- CLEAR:
  - Same banner count as HIT.
  - On expiry with `game_done`=1: go to OVER.
  - On expiry with `game_done`=0: scrolls_left←SCROLLS_PER_LEVEL, time_left←TIME_LIMIT_S, frame_cnt←0, go to PLAY. Lives are kept.
- OVER:
  - `move_en`=0. Counters frozen at their final values.
  - On `start_btn` rise: go to IDLE. A second rise is then needed to begin a new game.
- `start_btn` is ignored in PLAY, HIT and CLEAR.

## Timing
- All outputs are registered. A stimulus sampled on edge N produces its response at edge N, visible in cycle N+1.
- Pulses (`level_passed`, `lose`) are exactly one cycle wide. At most one of them fires per cycle.
- `wall_hit` edge detection uses a single previous-value register.
  - A rise that coincides with entry to HIT is consumed.
  - A level still high on return to PLAY does not fault again until it falls and rises.
- The seconds counter runs only in PLAY. Frames are counted only on `frame_tick`, never on `clk`.
- Reset asserted mid-round returns to IDLE asynchronously. No pulse is emitted on reset release.
- `game_done` is sampled only at CLEAR banner expiry.

## Structure
- Shared package `game_pkg` holds:
  - the state-code constants (`RS_IDLE` … `RS_OVER`);
  - width localparams for lives (3), scrolls (4) and time (7).
- Sub-module `frame_sec_timer` contains frame_cnt plus the time_left down-counter. Its interface:
  - inputs `load`, `run`;
  - output `expire` (one-cycle pulse at the 1→0 transition).
- The FSM, scroll and lives counters, and edge detectors stay in `round_sequencer`.

## Test plan
- Reset, then `start_btn` rise → state=1, `move_en`=1, lives=3, scrolls_left=4, time_left=60.
- Four `scroll_hit` pulses in PLAY → `level_passed` high for exactly one cycle on the 4th pulse. State=3 for 120 frame ticks, then state=1 with scrolls_left=4.
- `wall_hit` rise with lives=3 → lives=2, state=2, `move_en`=0. After 120 frame ticks, state=1 and time_left=60. A `wall_hit` held high raises no second fault.
- 3600 frame ticks with no input and lives=1 → time_left reaches 0, `lose` pulses once, state=4.
- Last `scroll_hit` and `wall_hit` rise in the same cycle → `level_passed` pulses, lives unchanged, state=3.
- `rst` asserted low mid-HIT → immediate state=0, all outputs 0. After release, no pulse and nothing happens until a `start_btn` rise.
